// File: rtl/rv32m_iterative_divider.sv
// rv32m_iterative_divider
// -----------------------
// Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU) living in EX beside
// the single-cycle ALU. One operation is issued with a start pulse; the
// pipeline stalls on busy and writes result back to rd_out when done pulses.
// Normal operations take 32 restoring shift-subtract iterations plus one
// sign-fix cycle; divide-by-zero and signed overflow finish right away with
// the RISC-V defined results.
//
// Ports:
//   CLK       in   clock, rising edge
//   RESET     in   asynchronous active-high reset
//   start     in   one-cycle request, sampled only while idle
//   op        in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   rs1 value
//   divisor   in   rs2 value
//   rd_in     in   destination register tag, captured with start
//   kill      in   pipeline flush, aborts any in-flight operation
//   busy      out  high while an operation is in flight (CALC/FIX/DONE)
//   done      out  one-cycle pulse, result and rd_out valid while high
//   result    out  quotient or remainder, held until the next completion
//   rd_out    out  destination tag of the completed operation

module rv32m_iterative_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic [4:0]       rd_in,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       rd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(XLEN - 1);

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic [2*XLEN-1:0]  rem_quo;
    logic [XLEN-1:0]    dvs_mag;
    logic               op_rem;
    logic               neg_quo;
    logic               neg_rem;
    logic [4:0]         rd_q;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic               div_zero;
    logic               overflow;
    logic [XLEN-1:0]    special_result;

    logic [XLEN:0]      partial;
    logic [XLEN+1:0]    diff;
    logic               borrow;
    logic [2*XLEN-1:0]  step_next;

    logic [XLEN-1:0]    quo_raw;
    logic [XLEN-1:0]    rem_raw;
    logic [XLEN-1:0]    fixed_result;

    // Operand decode at issue: magnitudes for the unsigned core, and the
    // two early-out cases. For signed overflow the dividend itself is the
    // architectural DIV answer (0x80000000), so it is reused directly.
    always_comb begin
        is_signed      = ~op[0];
        a_neg          = is_signed & dividend[XLEN-1];
        b_neg          = is_signed & divisor[XLEN-1];
        a_mag          = a_neg ? (~dividend + ONE) : dividend;
        b_mag          = b_neg ? (~divisor + ONE) : divisor;
        div_zero       = (divisor == '0);
        overflow       = is_signed && (dividend == MOST_NEG) && (divisor == '1);
        special_result = '0;
        if (div_zero) begin
            special_result = op[1] ? dividend : '1;
        end else begin
            special_result = op[1] ? '0 : dividend;
        end
    end

    // One restoring iteration: the remainder half shifted left with the next
    // dividend bit forms a 33-bit partial; the trial subtraction is one bit
    // wider again so its top bit is a clean borrow that selects restore.
    always_comb begin
        partial   = rem_quo[2*XLEN-1:XLEN-1];
        diff      = {1'b0, partial} - {2'b00, dvs_mag};
        borrow    = diff[XLEN+1];
        step_next = '0;
        if (borrow) begin
            step_next = {partial[XLEN-1:0], rem_quo[XLEN-2:0], 1'b0};
        end else begin
            step_next = {diff[XLEN-1:0], rem_quo[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction applied in FIX: quotient negative when operand signs
    // differ, remainder follows the dividend's sign.
    always_comb begin
        quo_raw      = rem_quo[XLEN-1:0];
        rem_raw      = rem_quo[2*XLEN-1:XLEN];
        fixed_result = '0;
        if (op_rem) begin
            fixed_result = neg_rem ? (~rem_raw + ONE) : rem_raw;
        end else begin
            fixed_result = neg_quo ? (~quo_raw + ONE) : quo_raw;
        end
    end

    // Control FSM with registered busy/done. result and rd_out only change
    // when an operation actually completes, so a kill or reset mid-flight
    // never exposes a partial answer and the last good value is held.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            counter <= '0;
            rem_quo <= '0;
            dvs_mag <= '0;
            op_rem  <= 1'b0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            rd_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        op_rem  <= op[1];
                        rd_q    <= rd_in;
                        neg_quo <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dvs_mag <= b_mag;
                        rem_quo <= {{XLEN{1'b0}}, a_mag};
                        counter <= '0;
                        busy    <= 1'b1;
                        if (div_zero || overflow) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= special_result;
                            rd_out <= rd_in;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem_quo <= step_next;
                        counter <= counter + 1'b1;
                        if (counter == LAST_IT) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (kill) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        result <= fixed_result;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
